// File: rtl/egress_fsm.sv
// Egress side of the frame path: drains buffered frames onto a registered AXIS stream with
// preamble/SFD prepended, or silently discards frames whose status entry says drop.

`ifndef STUBBING_PASSTHROUGH
`define STUBBING_PASSTHROUGH 0
`endif

typedef struct packed {
    logic        tvalid;
    logic [15:0] tdata;
    logic        tlast;
} axis_source_t;

typedef struct packed {
    logic tready;
} axis_sink_t;

typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    FRAME    = 3'd3,
    DISCARD  = 3'd4
} egress_state_t;

module egress_fsm #(
    parameter int          STUBBING       = `STUBBING_PASSTHROUGH,
    parameter int          PREAMBLE_WORDS = 3,
    parameter logic [15:0] PREAMBLE_WORD  = 16'hAAAA,
    parameter logic [15:0] SFD_WORD       = 16'hAAAB
) (
    input  logic         i_clk,
    input  logic         i_reset,
    output axis_source_t o_egress_source,
    input  axis_sink_t   i_egress_sink,
    input  logic         i_buf_empty,
    input  logic [15:0]  i_buf_rd_data,
    input  logic         i_buf_rd_last,
    output logic         o_buf_rd_en,
    input  logic         i_stat_empty,
    input  logic         i_stat_drop,
    output logic         o_stat_rd_en,
    output logic [15:0]  o_frames_sent,
    output logic [15:0]  o_frames_dropped
);

    localparam logic [2:0] PRE_LAST = 3'(PREAMBLE_WORDS - 1);

    egress_state_t r_state;
    logic [2:0]    r_preCnt;
    logic          r_tvalid;
    logic [15:0]   r_tdata;
    logic          r_tlast;
    logic [15:0]   r_framesSent;
    logic [15:0]   r_framesDropped;

    egress_state_t w_nextState;
    logic [2:0]    w_nextPreCnt;
    logic          w_loadEn;
    logic          w_load;
    logic [15:0]   w_loadData;
    logic          w_loadLast;
    logic          w_bufRdEn;
    logic          w_statRdEn;
    logic          w_dropDone;
    logic          w_lastXfer;

    // The output register may only be refilled once its current beat is gone or was never valid.
    assign w_loadEn   = ~r_tvalid | i_egress_sink.tready;
    assign w_lastXfer = r_tvalid & i_egress_sink.tready & r_tlast;

    always_comb begin
        w_nextState  = r_state;
        w_nextPreCnt = r_preCnt;
        w_load       = 1'b0;
        w_loadData   = r_tdata;
        w_loadLast   = 1'b0;
        w_bufRdEn    = 1'b0;
        w_statRdEn   = 1'b0;
        w_dropDone   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_stat_empty) begin
                    w_statRdEn = 1'b1;
                    if (i_stat_drop) begin
                        w_nextState = DISCARD;
                    end else begin
                        w_nextState  = PREAMBLE;
                        w_nextPreCnt = 3'd0;
                    end
                end
            end
            PREAMBLE: begin
                if (w_loadEn) begin
                    w_load       = 1'b1;
                    w_loadData   = PREAMBLE_WORD;
                    w_nextPreCnt = r_preCnt + 3'd1;
                    if (r_preCnt == PRE_LAST) begin
                        w_nextState = SFD;
                    end
                end
            end
            SFD: begin
                if (w_loadEn) begin
                    w_load      = 1'b1;
                    w_loadData  = SFD_WORD;
                    w_nextState = FRAME;
                end
            end
            FRAME: begin
                if (w_loadEn && !i_buf_empty) begin
                    w_load     = 1'b1;
                    w_loadData = i_buf_rd_data;
                    w_loadLast = i_buf_rd_last;
                    w_bufRdEn  = 1'b1;
                    if (i_buf_rd_last) begin
                        w_nextState = IDLE;
                    end
                end
            end
            DISCARD: begin
                // Egress is left alone here so the previous frame's final beat can still drain.
                if (!i_buf_empty) begin
                    w_bufRdEn = 1'b1;
                    if (i_buf_rd_last) begin
                        w_dropDone  = 1'b1;
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_preCnt        <= 3'd0;
            r_tvalid        <= 1'b0;
            r_tdata         <= 16'h0000;
            r_tlast         <= 1'b0;
            r_framesSent    <= 16'h0000;
            r_framesDropped <= 16'h0000;
        end else begin
            r_state  <= w_nextState;
            r_preCnt <= w_nextPreCnt;
            if (w_loadEn) begin
                r_tvalid <= w_load;
                r_tlast  <= w_loadLast;
                if (w_load) begin
                    r_tdata <= w_loadData;
                end
            end
            if (w_lastXfer) begin
                r_framesSent <= r_framesSent + 16'd1;
            end
            if (w_dropDone) begin
                r_framesDropped <= r_framesDropped + 16'd1;
            end
        end
    end

    // Pops are held off while reset is asserted so a reset never consumes buffer entries.
    assign o_buf_rd_en             = w_bufRdEn & ~i_reset;
    assign o_stat_rd_en            = w_statRdEn & ~i_reset;
    assign o_egress_source.tvalid  = r_tvalid;
    assign o_egress_source.tdata   = r_tdata;
    assign o_egress_source.tlast   = r_tlast;
    assign o_frames_sent           = r_framesSent;
    assign o_frames_dropped        = r_framesDropped;

endmodule

// File: tb/tb_egress_fsm.sv
// Scoreboard bench for egress_fsm: FWFT buffer/status models feed the DUT, expected beats are
// queued as frames are offered and checked as they leave on egress.

module tb_egress_fsm;

    localparam int PRE_WORDS = 3;

    logic        clk;
    logic        reset;
    logic [17:0] egressSource;
    logic        tready;
    logic        bufEmpty;
    logic [15:0] bufRdData;
    logic        bufRdLast;
    logic        bufRdEn;
    logic        statEmpty;
    logic        statDrop;
    logic        statRdEn;
    logic [15:0] framesSent;
    logic [15:0] framesDropped;

    wire         sVal  = egressSource[17];
    wire  [15:0] sData = egressSource[16:1];
    wire         sLast = egressSource[0];

    logic [16:0] bufQ[$];
    bit          statQ[$];
    logic [16:0] expQ[$];
    logic [15:0] stageQ[$];

    int          testsRun = 0;
    int          failCount = 0;
    bit          holdEmpty = 0;
    bit          gapArm = 0;
    int          gapCnt = 0;
    bit          toggleReady = 0;
    bit          prevStall = 0;
    logic [15:0] prevData = '0;
    logic        prevLast = 1'b0;

    egress_fsm dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .o_egress_source  (egressSource),
        .i_egress_sink    (tready),
        .i_buf_empty      (bufEmpty),
        .i_buf_rd_data    (bufRdData),
        .i_buf_rd_last    (bufRdLast),
        .o_buf_rd_en      (bufRdEn),
        .i_stat_empty     (statEmpty),
        .i_stat_drop      (statDrop),
        .o_stat_rd_en     (statRdEn),
        .o_frames_sent    (framesSent),
        .o_frames_dropped (framesDropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic void updateFifo();
        bufEmpty = (bufQ.size() == 0) || holdEmpty;
        if (bufQ.size() != 0) {bufRdLast, bufRdData} = bufQ[0];
        else {bufRdLast, bufRdData} = 17'h0;
        statEmpty = (statQ.size() == 0);
        statDrop  = (statQ.size() != 0) ? statQ[0] : 1'b0;
    endfunction

    // Offers the staged words as one complete frame; the status entry goes in last.
    task automatic applyStimulus(input bit drop);
        if (!drop) begin
            for (int i = 0; i < PRE_WORDS; i++) expQ.push_back({1'b0, 16'hAAAA});
            expQ.push_back({1'b0, 16'hAAAB});
        end
        for (int i = 0; i < stageQ.size(); i++) begin
            bufQ.push_back({(i == stageQ.size() - 1), stageQ[i]});
            if (!drop) expQ.push_back({(i == stageQ.size() - 1), stageQ[i]});
        end
        statQ.push_back(drop);
        stageQ.delete();
        updateFifo();
    endtask

    task automatic stageT1();
        stageQ.push_back(16'h1111);
        stageQ.push_back(16'h2222);
        stageQ.push_back(16'h3333);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bufQ.delete();
        statQ.delete();
        expQ.delete();
        holdEmpty = 0;
        gapCnt = 0;
        updateFifo();
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((expQ.size() != 0 || bufQ.size() != 0 || statQ.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drainTimeout"}, 32'(n < 500), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // FIFO models pop on the edge where the DUT asserted the read enable.
    always @(posedge clk) begin
        bit popBuf;
        bit popStat;
        logic [16:0] w;
        popBuf  = bufRdEn;
        popStat = statRdEn;
        #1;
        if (gapCnt > 0) begin
            gapCnt--;
            if (gapCnt == 0) holdEmpty = 0;
        end
        if (popBuf && bufQ.size() != 0) begin
            w = bufQ.pop_front();
            if (gapArm && w[15:0] == 16'h1111) begin
                gapArm = 0;
                gapCnt = 3;
                holdEmpty = 1;
            end
        end
        if (popStat && statQ.size() != 0) void'(statQ.pop_front());
        updateFifo();
    end

    always @(posedge clk) begin
        if (toggleReady) begin
            #1 tready = ~tready;
        end
    end

    // Egress monitor: stall stability plus in-order scoreboard comparison of every handshake.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!reset) begin
            if (prevStall) begin
                checkOutput("stallValid", {31'b0, sVal}, 32'd1);
                checkOutput("stallData", {16'b0, sData}, {16'b0, prevData});
                checkOutput("stallLast", {31'b0, sLast}, {31'b0, prevLast});
            end
            if (sVal && tready) begin
                checkOutput("beatExpected", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("beat", {15'b0, sLast, sData}, {15'b0, e});
                end
            end
            prevStall = sVal && !tready;
            prevData  = sData;
            prevLast  = sLast;
        end else begin
            prevStall = 0;
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        tready = 1'b1;
        updateFifo();

        // T1: reset state, basic frame, first-beat latency
        resetDut();
        checkOutput("rstValid", {31'b0, sVal}, 32'd0);
        checkOutput("rstData", {16'b0, sData}, 32'd0);
        checkOutput("rstLast", {31'b0, sLast}, 32'd0);
        checkOutput("rstBufRd", {31'b0, bufRdEn}, 32'd0);
        checkOutput("rstStatRd", {31'b0, statRdEn}, 32'd0);
        checkOutput("rstSent", {16'b0, framesSent}, 32'd0);
        checkOutput("rstDropped", {16'b0, framesDropped}, 32'd0);
        stageT1();
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("latencyIdle", {31'b0, sVal}, 32'd0);
        @(negedge clk);
        checkOutput("latencyFirst", {15'b0, sVal, sData}, {15'b0, 1'b1, 16'hAAAA});
        waitDrain("t1");
        checkOutput("t1Sent", {16'b0, framesSent}, 32'd1);

        // T2: dropped frame followed by a transmitted one
        resetDut();
        stageQ.push_back(16'hDEAD);
        stageQ.push_back(16'hBEEF);
        applyStimulus(1'b1);
        stageQ.push_back(16'h0001);
        stageQ.push_back(16'h0002);
        applyStimulus(1'b0);
        waitDrain("t2");
        checkOutput("t2Dropped", {16'b0, framesDropped}, 32'd1);
        checkOutput("t2Sent", {16'b0, framesSent}, 32'd1);

        // T3: tready toggling every cycle
        resetDut();
        toggleReady = 1;
        stageT1();
        applyStimulus(1'b0);
        waitDrain("t3");
        toggleReady = 0;
        @(negedge clk);
        tready = 1'b1;
        checkOutput("t3Sent", {16'b0, framesSent}, 32'd1);

        // T4: buffer underrun after the first frame word
        resetDut();
        gapArm = 1;
        stageT1();
        applyStimulus(1'b0);
        n = 0;
        while (!holdEmpty && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4GapTimeout", 32'(n < 200), 32'd1);
        @(negedge clk);
        checkOutput("t4GapValid", {31'b0, sVal}, 32'd0);
        waitDrain("t4");
        checkOutput("t4Sent", {16'b0, framesSent}, 32'd1);

        // T5: reset in the middle of a frame, then a fresh frame
        resetDut();
        stageT1();
        applyStimulus(1'b0);
        n = 0;
        while (!(sVal && sData == 16'h2222) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5BeatTimeout", 32'(n < 200), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5Valid", {31'b0, sVal}, 32'd0);
        checkOutput("t5State", {29'b0, dut.r_state}, 32'd0);
        checkOutput("t5Sent", {16'b0, framesSent}, 32'd0);
        bufQ.delete();
        statQ.delete();
        expQ.delete();
        updateFifo();
        reset = 1'b0;
        @(negedge clk);
        stageT1();
        applyStimulus(1'b0);
        waitDrain("t5");
        checkOutput("t5SentAfter", {16'b0, framesSent}, 32'd1);

        // T6: frames_sent wraps from 0xFFFF to 0
        resetDut();
        force dut.r_framesSent = 16'hFFFF;
        @(negedge clk);
        release dut.r_framesSent;
        @(negedge clk);
        checkOutput("t6Preset", {16'b0, framesSent}, 32'h0000FFFF);
        stageQ.push_back(16'h5A5A);
        applyStimulus(1'b0);
        waitDrain("t6");
        checkOutput("t6Wrap", {16'b0, framesSent}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
